// File: rtl/irq_controller.sv
// irq_controller: vectored interrupt controller with synchronizers, mask/pending regs and req/ack/EOI handshake.
// Define IRQ_CONTROLLER_ROUNDROBIN_EN for round-robin arbitration (last_grant readable in CTRL[6:4]).
module irq_controller #(
    parameter int NUM_IRQ = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               ph1,
    input  logic               reset_b,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               cpu_irq,
    output logic [2:0]         irq_id,
    input  logic               cpu_ack,
    output logic               in_service
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state, state_n;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] hist, mask, pending, elig, rise, clr;
    logic [7:0] elig8, ack_oh;
    logic [2:0] win, last_grant;
    logic enable, ack, wr_mask, wr_pend, wr_ctrl, wr_eoi, unused_ok;

    assign rise = sync_q[SYNC_STAGES-1] & ~hist;
    assign elig = pending & mask & {NUM_IRQ{enable}};
    assign elig8 = 8'(elig);
    assign ack = state == REQ && cpu_ack;
    assign ack_oh = 8'b1 << irq_id;
    assign wr_mask = cfg_we && cfg_addr == 2'd0;
    assign wr_pend = cfg_we && cfg_addr == 2'd1;
    assign wr_ctrl = cfg_we && cfg_addr == 2'd2;
    assign wr_eoi = cfg_we && cfg_addr == 2'd3;
    // set wins over a same-cycle clear because rise is OR-ed after masking
    assign clr = (wr_pend ? cfg_wdata[NUM_IRQ-1:0] : '0) | (ack ? ack_oh[NUM_IRQ-1:0] : '0);
    assign cpu_irq = state == REQ;
    assign in_service = state == SERVICE;
    assign unused_ok = ^{cfg_wdata, ack_oh, elig8};
    assign cfg_rdata = cfg_addr == 2'd0 ? 32'(mask) :
                       cfg_addr == 2'd1 ? 32'(pending) :
                       cfg_addr == 2'd2 ? {25'd0, last_grant, 2'd0, in_service, enable} : '0;

`ifdef IRQ_CONTROLLER_ROUNDROBIN_EN
    // scan downward so the nearest index after last_grant is assigned last
    always_comb begin
        win = '0;
        for (int k = NUM_IRQ; k >= 1; k--)
            if (elig[(32'(last_grant) + k) % NUM_IRQ]) win = 3'((32'(last_grant) + k) % NUM_IRQ);
    end

    always_ff @(posedge ph1 or negedge reset_b)
        if (!reset_b) last_grant <= '0;
        else if (ack) last_grant <= irq_id;
`else
    always_comb begin
        win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (elig[i]) win = 3'(i);
    end

    assign last_grant = '0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |elig ? REQ : IDLE;
            REQ:     state_n = cpu_ack ? SERVICE : !elig8[irq_id] ? IDLE : REQ;
            SERVICE: state_n = wr_eoi ? IDLE : SERVICE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset_b)
        if (!reset_b) begin
            state <= IDLE;
            irq_id <= '0;
            hist <= '0;
            mask <= '0;
            pending <= '0;
            enable <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |elig) irq_id <= win;
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist <= sync_q[SYNC_STAGES-1];
            pending <= (pending & ~clr) | rise;
            if (wr_mask) mask <= cfg_wdata[NUM_IRQ-1:0];
            if (wr_ctrl) enable <= cfg_wdata[0];
        end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller.
module tb_irq_controller;
    logic ph1 = 1'b0, reset_b, cfg_we, cpu_ack, cpu_irq, in_service;
    logic [7:0] irq_in;
    logic [1:0] cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic [2:0] irq_id;
    int n_chk = 0, n_pass = 0;
`ifdef IRQ_CONTROLLER_ROUNDROBIN_EN
    localparam logic [31:0] FIRST = 1, SECOND = 0, LEFT = 1;
`else
    localparam logic [31:0] FIRST = 0, SECOND = 1, LEFT = 2;
`endif

    irq_controller dut (
        .ph1(ph1), .reset_b(reset_b), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cpu_irq(cpu_irq), .irq_id(irq_id),
        .cpu_ack(cpu_ack), .in_service(in_service)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ph1);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_in = m;
        tick(1);
        irq_in = '0;
    endtask

    task automatic ack_eoi;
        cpu_ack = 1'b1;
        tick(1);
        cpu_ack = 1'b0;
        wr(2'd3, 32'd0);
    endtask

    initial begin
        reset_b = 1'b0;
        irq_in = '0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        cpu_ack = 1'b0;
        tick(2);
        check("rst_irq", 32'(cpu_irq), 0);
        check("rst_id", 32'(irq_id), 0);
        check("rst_svc", 32'(in_service), 0);
        rd("rst_mask", 2'd0, 0);
        rd("rst_pend", 2'd1, 0);
        rd("rst_ctrl", 2'd2, 0);
        reset_b = 1'b1;
        tick(1);
        // basic flow: pending at 3rd edge, request after 4th
        wr(2'd0, 32'h01);
        wr(2'd2, 32'h01);
        rd("mask_rw", 2'd0, 32'h01);
        pulse(8'h01);
        tick(2);
        rd("pend_set", 2'd1, 32'h01);
        check("no_req_yet", 32'(cpu_irq), 0);
        tick(1);
        check("req", 32'(cpu_irq), 1);
        check("req_id", 32'(irq_id), 0);
        cpu_ack = 1'b1;
        tick(1);
        cpu_ack = 1'b0;
        check("ack_irq", 32'(cpu_irq), 0);
        check("ack_svc", 32'(in_service), 1);
        rd("ack_pend", 2'd1, 0);
        rd("ctrl_svc", 2'd2, 32'h03);
        wr(2'd3, 32'd0);
        check("eoi_svc", 32'(in_service), 0);
        rd("eoi_read", 2'd3, 0);
        // priority
        wr(2'd0, 32'hFF);
        pulse(8'h03);
        tick(3);
        check("pri_irq", 32'(cpu_irq), 1);
        check("pri_first", 32'(irq_id), FIRST);
        cpu_ack = 1'b1;
        tick(1);
        cpu_ack = 1'b0;
        rd("pri_pend", 2'd1, 32'(1) << LEFT[2:0] >> 1);
        wr(2'd3, 32'd0);
        tick(1);
        check("pri_irq2", 32'(cpu_irq), 1);
        check("pri_second", 32'(irq_id), SECOND);
        ack_eoi();
        rd("pri_pend0", 2'd1, 0);
        // mask withdraw and reissue
        pulse(8'h02);
        tick(3);
        check("wd_id", 32'(irq_id), 1);
        wr(2'd0, 32'h00);
        check("wd_hold", 32'(cpu_irq), 1);
        tick(1);
        check("wd_drop", 32'(cpu_irq), 0);
        rd("wd_pend", 2'd1, 32'h02);
        wr(2'd0, 32'h02);
        tick(1);
        check("wd_reissue", 32'(cpu_irq), 1);
        check("wd_reid", 32'(irq_id), 1);
        ack_eoi();
        wr(2'd0, 32'hFF);
        // W1C on the same edge as the set: set wins
        pulse(8'h04);
        tick(1);
        wr(2'd1, 32'h04);
        rd("col_pend", 2'd1, 32'h04);
        tick(1);
        check("col_id", 32'(irq_id), 2);
        ack_eoi();
        // held-high line sets pending once
        wr(2'd0, 32'h00);
        irq_in = 8'h08;
        tick(5);
        rd("hold_pend", 2'd1, 32'h08);
        wr(2'd1, 32'h08);
        tick(15);
        rd("hold_noretrig", 2'd1, 0);
        irq_in = '0;
        wr(2'd0, 32'hFF);
        // nested arrival during service
        pulse(8'h01);
        tick(3);
        cpu_ack = 1'b1;
        tick(1);
        cpu_ack = 1'b0;
        pulse(8'h02);
        tick(4);
        rd("nest_pend", 2'd1, 32'h02);
        check("nest_noirq", 32'(cpu_irq), 0);
        check("nest_svc", 32'(in_service), 1);
        wr(2'd3, 32'd0);
        tick(1);
        check("nest_irq", 32'(cpu_irq), 1);
        check("nest_id", 32'(irq_id), 1);
        // async reset between edges while requesting
        #2;
        reset_b = 1'b0;
        #1;
        check("ar_irq", 32'(cpu_irq), 0);
        check("ar_svc", 32'(in_service), 0);
        rd("ar_mask", 2'd0, 0);
        rd("ar_pend", 2'd1, 0);
        tick(1);
        reset_b = 1'b1;
        pulse(8'h01);
        tick(5);
        rd("ar_pend_new", 2'd1, 32'h01);
        check("ar_noreq", 32'(cpu_irq), 0);
        wr(2'd0, 32'h01);
        wr(2'd2, 32'h01);
        tick(1);
        check("ar_reconf", 32'(cpu_irq), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
